// File: rtl/riscv_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests and buffers
// returned instructions in a 2-entry queue handed to decode over valid/ready.
module riscv_fetch #(
   parameter int unsigned     XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            clk,
   input  logic            resetn,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] next_pc
);

   localparam logic [2:0] DEPTH_C = 3'(DEPTH);

   function automatic logic [XLEN-1:0] inc4(input logic [XLEN-1:0] a);
      return a + {{(XLEN-3){1'b0}}, 3'd4};
   endfunction

   logic [XLEN-1:0] pc_r, rsp_pc_r, pc_n_s, rsp_pc_n_s, redir_pc_s;
   logic [1:0]      count_r, outst_r, drop_r;
   logic [1:0]      count_n_s, outst_n_s, drop_n_s;
   logic            head_r, head_n_s, tail_s;
   logic [2:0]      credit_s;
   logic            req_valid_s, req_fire_s, rsp_keep_s, pop_s, wr_s;
   logic [XLEN-1:0] buf_pc_r    [0:1];
   logic [31:0]     buf_instr_r [0:1];

   // Handshake decode; buffer slots are credit-reserved against outstanding requests
   always_comb begin
      credit_s    = {1'b0, count_r} + {1'b0, outst_r} - {1'b0, drop_r};
      req_valid_s = resetn && !redirect_valid && (credit_s < DEPTH_C);
      req_fire_s  = req_valid_s && imem_req_ready;
      rsp_keep_s  = imem_rsp_valid && (drop_r == 2'd0);
      pop_s       = (count_r != 2'd0) && out_ready;
      wr_s        = rsp_keep_s && !redirect_valid;
      tail_s      = head_r ^ count_r[0];
      redir_pc_s  = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
   end

   // Next-state computation; a redirect overrides every other update
   always_comb begin
      pc_n_s     = pc_r;
      rsp_pc_n_s = rsp_pc_r;
      count_n_s  = count_r;
      outst_n_s  = outst_r;
      drop_n_s   = drop_r;
      head_n_s   = head_r;
      if (redirect_valid) begin
         pc_n_s     = redir_pc_s;
         rsp_pc_n_s = redir_pc_s;
         count_n_s  = 2'd0;
         outst_n_s  = outst_r - {1'b0, imem_rsp_valid};
         // everything still in flight belongs to the old path
         drop_n_s   = outst_r - {1'b0, imem_rsp_valid};
      end else begin
         if (req_fire_s) begin
            pc_n_s = inc4(pc_r);
         end else begin
            pc_n_s = pc_r;
         end
         if (rsp_keep_s) begin
            rsp_pc_n_s = inc4(rsp_pc_r);
         end else begin
            rsp_pc_n_s = rsp_pc_r;
         end
         if (imem_rsp_valid && (drop_r != 2'd0)) begin
            drop_n_s = drop_r - 2'd1;
         end else begin
            drop_n_s = drop_r;
         end
         if (pop_s) begin
            head_n_s = ~head_r;
         end else begin
            head_n_s = head_r;
         end
         outst_n_s = outst_r + {1'b0, req_fire_s} - {1'b0, imem_rsp_valid};
         count_n_s = count_r + {1'b0, rsp_keep_s} - {1'b0, pop_s};
      end
   end

   // Control and PC state registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_r     <= RESET_PC;
         rsp_pc_r <= RESET_PC;
         count_r  <= 2'd0;
         outst_r  <= 2'd0;
         drop_r   <= 2'd0;
         head_r   <= 1'b0;
      end else begin
         pc_r     <= pc_n_s;
         rsp_pc_r <= rsp_pc_n_s;
         count_r  <= count_n_s;
         outst_r  <= outst_n_s;
         drop_r   <= drop_n_s;
         head_r   <= head_n_s;
      end
   end

   // Instruction buffer storage, written at the tail by accepted responses
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         buf_pc_r[0]    <= RESET_PC;
         buf_pc_r[1]    <= RESET_PC;
         buf_instr_r[0] <= 32'h0;
         buf_instr_r[1] <= 32'h0;
      end else if (wr_s) begin
         buf_pc_r[tail_s]    <= rsp_pc_r;
         buf_instr_r[tail_s] <= imem_rsp_data;
      end
   end

   assign imem_req_valid = req_valid_s;
   assign imem_req_addr  = pc_r;
   assign pc             = pc_r;
   assign next_pc        = inc4(pc_r);
   assign out_valid      = (count_r != 2'd0);
   assign out_pc         = buf_pc_r[head_r];
   assign out_instr      = buf_instr_r[head_r];

endmodule

// File: tb/tb_riscv_fetch.sv
// Scoreboard bench for riscv_fetch: a behavioural memory/PC model predicts the
// in-order {pc, instr} stream, including redirects, drops and a wrapping reset PC.
module tb_riscv_fetch;

   localparam logic [63:0] RST = 64'hFFFF_FFFF_FFFF_FFF8;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic [63:0] maddr;
      int          due;
      bit          stale;
   } ent_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        imem_req_valid, imem_req_ready = 1'b0;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
   logic        out_valid, out_ready = 1'b0;
   logic [63:0] out_pc, pc, next_pc;
   logic [31:0] out_instr;

   ent_t        pend_q[$];
   ent_t        sb_q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [63:0] exp_pc = RST;
   int          ordy_mode = 1, rrdy_mode = 1;
   int unsigned lat_max = 1;
   bit          redir_en = 1'b0;
   int          nreq = 0, first_fire = -1, first_out = -1;

   logic        prev_hold = 1'b0, prev_redir = 1'b0;
   logic [63:0] prev_pc = 64'h0;
   logic [31:0] prev_instr = 32'h0;

   riscv_fetch #(.XLEN(64), .RESET_PC(RST), .DEPTH(2)) dut (
      .clk(clk), .resetn(resetn),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
      .pc(pc), .next_pc(next_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   // Monitor: compares every delivered head against the scoreboard
   always @(negedge clk) begin
      ent_t e;
      if (!resetn) begin
         prev_hold  <= 1'b0;
         prev_redir <= 1'b0;
      end else begin
         if (prev_redir) begin
            check("empty_after_redirect", {63'h0, out_valid}, 64'h0);
         end else if (prev_hold) begin
            check("hold_valid", {63'h0, out_valid}, 64'h1);
            check("hold_pc", out_pc, prev_pc);
            check("hold_instr", {32'h0, out_instr}, {32'h0, prev_instr});
         end
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_out: got pc %h, want no output", out_pc);
            end else begin
               e = sb_q.pop_front();
               check("out_pc", out_pc, e.pc);
               check("out_instr", {32'h0, out_instr}, {32'h0, e.instr});
            end
         end
         prev_hold  <= out_valid && !out_ready;
         prev_redir <= redirect_valid;
         prev_pc    <= out_pc;
         prev_instr <= out_instr;
      end
   end

   task automatic drive();
      int unsigned r;
      out_ready      = (ordy_mode == 1) ? 1'b1 : (ordy_mode == 2) ? ($urandom_range(3) != 0) : 1'b0;
      imem_req_ready = (rrdy_mode == 1) ? 1'b1 : (rrdy_mode == 2) ? ($urandom_range(1) == 1) : 1'b0;
      redirect_valid = redir_en && ($urandom_range(15) == 0);
      r = $urandom_range(3);
      redirect_pc = (r == 0) ? 64'h1003 : (r == 1) ? 64'hFFFF_FFFF_FFFF_FFF5 :
                    (r == 2) ? 64'h0 : {$urandom, $urandom};
      if (pend_q.size() > 0 && cyc + 1 >= pend_q[0].due) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = pend_q[0].maddr[31:0] ^ KEY;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   endtask

   // One clock: observe the cycle at negedge, update the model, drive the next cycle
   task automatic step();
      logic fire, rsp, red;
      ent_t p;
      @(negedge clk);
      cyc++;
      fire = imem_req_valid && imem_req_ready;
      rsp  = imem_rsp_valid;
      red  = redirect_valid;
      check("pc", pc, exp_pc);
      check("next_pc", next_pc, exp_pc + 64'd4);
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
      if (red) check("req_in_redirect", {63'h0, imem_req_valid}, 64'h0);
      if (fire && first_fire < 0) first_fire = cyc;
      if (out_valid && first_out < 0) first_out = cyc;
      if (rsp && pend_q.size() > 0) begin
         p = pend_q.pop_front();
         if (!p.stale && !red) sb_q.push_back(p);
      end
      if (red) foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      if (fire) begin
         p.pc    = exp_pc;
         p.instr = exp_pc[31:0] ^ KEY;
         p.maddr = imem_req_addr;
         p.due   = cyc + int'($urandom_range(lat_max, 1));
         p.stale = 1'b0;
         pend_q.push_back(p);
         exp_pc = exp_pc + 64'd4;
         nreq++;
      end
      if (red) exp_pc = redirect_pc & ~64'h3;
      @(posedge clk);
      #1;
      if (red) sb_q.delete();
      drive();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      redirect_valid = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
      out_ready = 1'b0;
      pend_q.delete();
      sb_q.delete();
      exp_pc = RST;
      nreq = 0;
      first_fire = -1;
      first_out = -1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
      check("rst_out_valid", {63'h0, out_valid}, 64'h0);
      check("rst_out_pc", out_pc, RST);
      check("rst_out_instr", {32'h0, out_instr}, 64'h0);
      check("rst_pc", pc, RST);
      resetn = 1'b1;
      drive();
   endtask

   initial begin
      // 1-cycle memory, decode always ready: first output 2 cycles after first request
      ordy_mode = 1; rrdy_mode = 1; lat_max = 1; redir_en = 1'b0;
      do_reset();
      repeat (20) step();
      if (first_fire < 0 || first_out < 0) begin
         tests++;
         fails++;
         $display("FAIL first_latency: got no output within 20 cycles, want output");
      end else begin
         check("first_latency", 64'(first_out - first_fire), 64'd2);
      end

      // Decode stalled: exactly two requests, head held at the reset PC
      ordy_mode = 0;
      do_reset();
      repeat (12) step();
      check("stall_nreq", 64'(nreq), 64'd2);
      check("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
      check("stall_out_valid", {63'h0, out_valid}, 64'h1);
      check("stall_out_pc", out_pc, RST);
      ordy_mode = 1;
      repeat (12) step();

      // Random back-pressure, latency 1..3 and redirects
      ordy_mode = 2; rrdy_mode = 2; lat_max = 3; redir_en = 1'b1;
      repeat (300) step();

      // Asynchronous reset between clock edges
      #2;
      resetn = 1'b0;
      #1;
      check("async_out_valid", {63'h0, out_valid}, 64'h0);
      check("async_pc", pc, RST);
      check("async_req_valid", {63'h0, imem_req_valid}, 64'h0);
      do_reset();
      repeat (300) step();

      // Drain: no new requests; every accepted response must reach decode
      ordy_mode = 1; rrdy_mode = 0; redir_en = 1'b0;
      repeat (30) step();
      check("drain_sb", 64'(sb_q.size()), 64'd0);
      check("drain_pend", 64'(pend_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
